// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter_pkg
// Brief  : Shared widths and read-return tag types for the data-RAM arbiter.
// Rev    : 1.0
// ============================================================================
package dmem_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t owner;
    logic   valid;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{owner: OWN_NONE, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : CPU, VGA and RAM-side bus of the data-RAM arbiter (slave = arbiter).
// Rev    : 1.0
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = dmem_arbiter_pkg::DATA_W
);

  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  logic [31:0]       perf_cpu_stalls;
  logic [31:0]       perf_vga_grants;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  vga_req, vga_addr,
    output vga_ack, vga_rvalid, vga_rdata,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut,
    output perf_cpu_stalls, perf_vga_grants
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output vga_req, vga_addr,
    input  vga_ack, vga_rvalid, vga_rdata,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut,
    input  perf_cpu_stalls, perf_vga_grants
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module : arb_tag_pipe
// Brief  : DEPTH-stage shift register of read-return tags; head = oldest tag.
// Rev    : 1.0
// ============================================================================
module arb_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t push_tag,
  output rd_tag_t head_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= TAG_IDLE;
      end
    end else begin
      r_stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign head_tag = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : CPU-priority arbiter with VGA starvation guard for a shared data RAM.
//          Optional perf counters enabled by defining ARB_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] r_starve_cnt;
  logic            w_vga_win;
  logic            w_cpu_grant;
  rd_tag_t         w_push_tag;
  rd_tag_t         w_head_tag;

  // STARVE_MAX = 0 keeps the counter at its limit, so VGA always wins
  always_comb begin
    w_vga_win   = bus.vga_req && (!bus.cpu_req || (r_starve_cnt == C_STARVE_MAX));
    w_cpu_grant = bus.cpu_req && !w_vga_win;
  end

  assign bus.vga_ack   = w_vga_win;
  assign bus.cpu_stall = bus.cpu_req && !w_cpu_grant;

  always_comb begin
    bus.ram_addr = '0;
    if (w_vga_win) begin
      bus.ram_addr = bus.vga_addr;
    end else if (w_cpu_grant) begin
      bus.ram_addr = bus.cpu_addr;
    end
  end

  assign bus.ram_wEn    = w_cpu_grant && bus.cpu_wren && !reset;
  assign bus.ram_dataIn = bus.cpu_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!bus.vga_req || w_vga_win) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    w_push_tag = TAG_IDLE;
    if (w_vga_win) begin
      w_push_tag = '{owner: OWN_VGA, valid: 1'b1};
    end else if (w_cpu_grant && !bus.cpu_wren) begin
      w_push_tag = '{owner: OWN_CPU, valid: 1'b1};
    end
  end

  arb_tag_pipe #(
    .DEPTH (RAM_LAT)
  ) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .push_tag (w_push_tag),
    .head_tag (w_head_tag)
  );

  assign bus.cpu_rvalid = w_head_tag.valid && (w_head_tag.owner == OWN_CPU);
  assign bus.vga_rvalid = w_head_tag.valid && (w_head_tag.owner == OWN_VGA);
  assign bus.cpu_rdata  = bus.ram_dataOut;
  assign bus.vga_rdata  = bus.ram_dataOut;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_cpu_stalls;
  logic [31:0] r_perf_vga_grants;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_cpu_stalls <= '0;
      r_perf_vga_grants <= '0;
    end else begin
      if (bus.cpu_stall) begin
        r_perf_cpu_stalls <= r_perf_cpu_stalls + 32'd1;
      end
      if (w_vga_win) begin
        r_perf_vga_grants <= r_perf_vga_grants + 32'd1;
      end
    end
  end

  assign bus.perf_cpu_stalls = r_perf_cpu_stalls;
  assign bus.perf_vga_grants = r_perf_vga_grants;
`else
  assign bus.perf_cpu_stalls = '0;
  assign bus.perf_vga_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Randomized scoreboard bench for dmem_arbiter with a behavioural RAM.
// Rev    : 1.0
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int RAM_LAT    = 1;
  localparam int AW         = ADDR_W;
  localparam int DW         = DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus0 ();

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .RAM_LAT(RAM_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Second instance with STARVE_MAX = 0 sees the same requests; only its grants are checked
  dmem_arbiter #(.STARVE_MAX(0), .RAM_LAT(1)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  assign bus0.cpu_req     = bus.cpu_req;
  assign bus0.cpu_wren    = bus.cpu_wren;
  assign bus0.cpu_addr    = bus.cpu_addr;
  assign bus0.cpu_wdata   = bus.cpu_wdata;
  assign bus0.vga_req     = bus.vga_req;
  assign bus0.vga_addr    = bus.vga_addr;
  assign bus0.ram_dataOut = '0;

  // Behavioural write-first RAM with RAM_LAT-cycle read latency
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] rd_dly [RAM_LAT];

  always @(posedge clock) begin
    if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_dataIn;
    rd_dly[0] <= bus.ram_wEn ? bus.ram_dataIn : ram[bus.ram_addr];
    for (int i = 1; i < RAM_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end
  assign bus.ram_dataOut = rd_dly[RAM_LAT-1];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t vga_q[$];
  exp_t e;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int lost   = 0;
  int n_stall = 0, n_vga = 0, n_stall0 = 0, n_vga0 = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Return monitor: a due entry demands rvalid with its data, otherwise rvalid must be low
  always @(negedge clock) begin
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      e = cpu_q.pop_front();
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      chk("cpu_rdata", bus.cpu_rdata, e.data);
    end else begin
      chk("cpu_rvalid_idle", 32'(bus.cpu_rvalid), 32'd0);
    end
    if (vga_q.size() > 0 && vga_q[0].due == cyc) begin
      e = vga_q.pop_front();
      chk("vga_rvalid", 32'(bus.vga_rvalid), 32'd1);
      chk("vga_rdata", bus.vga_rdata, e.data);
    end else begin
      chk("vga_rvalid_idle", 32'(bus.vga_rvalid), 32'd0);
    end
  end

  task automatic step(input logic creq, input logic cwr, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic vreq, input logic [AW-1:0] vaddr,
                      input logic rst, output logic stalled, output logic vacked);
    logic          vwin, cgr;
    logic [AW-1:0] eaddr;
    @(posedge clock);
    #1;
    reset         = rst;
    bus.cpu_req   = creq;
    bus.cpu_wren  = cwr;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.vga_req   = vreq;
    bus.vga_addr  = vaddr;
    if (rst) begin
      cpu_q.delete();
      vga_q.delete();
      lost = 0; n_stall = 0; n_vga = 0; n_stall0 = 0; n_vga0 = 0;
    end
    vwin  = vreq && (!creq || lost == STARVE_MAX);
    cgr   = creq && !vwin;
    eaddr = vwin ? vaddr : (cgr ? caddr : '0);
    #3;
    chk("vga_ack", 32'(bus.vga_ack), 32'(vwin));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(creq && !cgr));
    chk("ram_wEn", 32'(bus.ram_wEn), 32'(cgr && cwr && !rst));
    chk("ram_addr", 32'(bus.ram_addr), 32'(eaddr));
    if (cgr && cwr) chk("ram_dataIn", bus.ram_dataIn, cwd);
    chk("sm0_vga_ack", 32'(bus0.vga_ack), 32'(vreq));
    chk("sm0_cpu_stall", 32'(bus0.cpu_stall), 32'(creq && vreq));
`ifdef ARB_PERF_CNT_EN
    chk("perf_cpu_stalls", bus.perf_cpu_stalls, 32'(n_stall));
    chk("perf_vga_grants", bus.perf_vga_grants, 32'(n_vga));
    chk("sm0_perf_cpu_stalls", bus0.perf_cpu_stalls, 32'(n_stall0));
    chk("sm0_perf_vga_grants", bus0.perf_vga_grants, 32'(n_vga0));
`else
    chk("perf_cpu_stalls", bus.perf_cpu_stalls, 32'd0);
    chk("perf_vga_grants", bus.perf_vga_grants, 32'd0);
`endif
    if (!rst) begin
      if (cgr && cwr) shadow[caddr] = cwd;
      else if (cgr) cpu_q.push_back('{due: cyc + RAM_LAT, data: shadow[caddr]});
      if (vwin) vga_q.push_back('{due: cyc + RAM_LAT, data: shadow[vaddr]});
      if (!vreq || vwin) lost = 0;
      else if (lost < STARVE_MAX) lost++;
      if (creq && !cgr) n_stall++;
      if (vwin) n_vga++;
      if (creq && vreq) n_stall0++;
      if (vreq) n_vga0++;
    end
    stalled = creq && !cgr;
    vacked  = vwin;
  endtask

  task automatic idle(input int n);
    logic s, a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, s, a);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic          st, ack, creq, cwr, vreq, rst;
    logic [AW-1:0] caddr, vaddr;
    logic [DW-1:0] cwd;

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'(i) * 32'h9E37_79B9;
      shadow[i] = ram[i];
    end
    ram[12'h010]    = 32'hDEAD_BEEF;
    shadow[12'h010] = 32'hDEAD_BEEF;
    bus.cpu_req = 1'b0; bus.cpu_wren = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;

    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, st, ack);
    idle(1);

    // CPU load of preloaded word
    step(1'b1, 1'b0, 12'h010, '0, 1'b0, '0, 1'b0, st, ack);
    idle(2);

    // Both masters continuously requesting
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 12'h030, '0, 1'b1, 12'h040, 1'b0, st, ack);
    idle(2);

    // Store then VGA read of the same word
    step(1'b1, 1'b1, 12'h020, 32'h1234_5678, 1'b0, '0, 1'b0, st, ack);
    step(1'b0, 1'b0, '0, '0, 1'b1, 12'h020, 1'b0, st, ack);
    idle(2);

    // VGA read dropped by reset; stores during reset must not reach the RAM
    step(1'b0, 1'b0, '0, '0, 1'b1, 12'h050, 1'b0, st, ack);
    step(1'b1, 1'b1, 12'h070, 32'hCAFE_F00D, 1'b1, 12'h050, 1'b1, st, ack);
    step(1'b1, 1'b1, 12'h070, 32'hCAFE_F00D, 1'b1, 12'h050, 1'b1, st, ack);
    idle(2);

    // Starvation count built up before reset must be cleared by it
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h031, '0, 1'b1, 12'h041, 1'b0, st, ack);
    step(1'b1, 1'b0, 12'h031, '0, 1'b1, 12'h041, 1'b1, st, ack);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 12'h031, '0, 1'b1, 12'h041, 1'b0, st, ack);
    idle(2);

    // Randomized traffic; stalled CPU and unacked VGA requests are held
    creq = 1'b0; cwr = 1'b0; caddr = '0; cwd = '0; vreq = 1'b0; vaddr = '0;
    st = 1'b0; ack = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!st) begin
        creq  = ($urandom_range(0, 99) < 70);
        cwr   = ($urandom_range(0, 2) == 0);
        caddr = AW'($urandom_range(0, 31));
        cwd   = $urandom();
      end
      if (!vreq || ack) begin
        vreq  = ($urandom_range(0, 99) < 60);
        vaddr = AW'($urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 149) == 0);
      step(creq, cwr, caddr, cwd, vreq, vaddr, rst, st, ack);
    end
    idle(4);

    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("vga_queue_drained", 32'(vga_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 12-bit x 32-bit data RAM between two masters: the CPU load/store port and the VGA framebuffer fetcher.
- Sits between the processor/VGA logic and the RAM instance. Issues at most one RAM access per cycle.
- Uses fixed CPU priority with a starvation guard for VGA, and tags in-flight reads so each return goes to the correct master.

Parameters:
- ADDR_W, 12: RAM address width.
- DATA_W, 32: RAM data width.
- STARVE_MAX, 4: consecutive VGA-lost cycles before VGA is forced to win. 0 means VGA always has priority.
- RAM_LAT, 1: RAM read latency in cycles (registered read). Legal range is 1–3.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (load or store) this cycle.
- cpu_wren  in  1  1 = store, 0 = load; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  CPU request not granted this cycle; CPU must hold its request.
- cpu_rvalid  out  1  CPU load data valid on cpu_rdata.
- cpu_rdata  out  DATA_W  CPU load data.
- vga_req  in  1  VGA read request; the VGA port is read-only.
- vga_addr  in  ADDR_W  VGA word address.
- vga_ack  out  1  VGA request accepted this cycle.
- vga_rvalid  out  1  VGA read data valid on vga_rdata.
- vga_rdata  out  DATA_W  VGA read data.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM read data, RAM_LAT cycles after the address is presented.
- perf_cpu_stalls  out  32  CPU stall-cycle count (feature-dependent).
- perf_vga_grants  out  32  VGA grant count (feature-dependent).

Behaviour:
- Grant decision is combinational, same cycle:
  - vga_win = vga_req && (!cpu_req || starve_cnt == STARVE_MAX).
  - cpu_grant = cpu_req && !vga_win.
  - vga_ack = vga_win.
  - cpu_stall = cpu_req && !cpu_grant.
- RAM drive:
  - Granted master's address appears on ram_addr.
  - ram_wEn = cpu_grant && cpu_wren; ram_dataIn = cpu_wdata.
  - No grant: ram_addr = 0, ram_wEn = 0.
  - ram_wEn is forced to 0 while reset is high.
- starve_cnt (registered):
  - Cleared when vga_req is low or VGA is granted.
  - Incremented, saturating at STARVE_MAX, when vga_req && !vga_win.
- Steady state with both masters requesting continuously and STARVE_MAX = N: N CPU grants, then 1 VGA grant, repeating.
- Return tagging:
  - Each granted read pushes tag {owner, valid} into a RAM_LAT-deep shift pipeline.
  - Writes and idle cycles push {NONE, 0}.
  - At the pipeline output, owner CPU asserts cpu_rvalid for 1 cycle; owner VGA asserts vga_rvalid for 1 cycle.
  - cpu_rdata and vga_rdata both follow ram_dataOut combinationally; their contents are meaningful only while the matching rvalid is high.
- Ordering: returns arrive in issue order, exactly RAM_LAT cycles after the grant cycle. Back-to-back reads give back-to-back rvalids.
- Read-after-write: a CPU store at A followed by any read of A in the next cycle returns the new data (RAM is write-first).
- Reset, asynchronous:
  - starve_cnt = 0; tag pipeline cleared; cpu_rvalid = vga_rvalid = 0.
  - In-flight reads are dropped and never produce rvalid.
  - Grant outputs follow requests combinationally, except that ram_wEn is held at 0.
- A request held across a stall must keep the same address and data; the arbiter does not latch requests.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: two 32-bit wrapping counters, cleared by reset.
  - perf_cpu_stalls increments each cycle cpu_stall = 1.
  - perf_vga_grants increments each cycle vga_ack = 1.
- Not defined: both perf ports are tied to 0 and no counter flops exist. The port list is unchanged either way.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W constants.
  - owner_t enum: OWN_NONE, OWN_CPU, OWN_VGA.
  - rd_tag_t struct: {owner_t owner; logic valid}.
- One sub-module: arb_tag_pipe. It is a RAM_LAT-deep shift register of rd_tag_t with async clear, and outputs the head tag.

Test Plan:
1. CPU load only, addr 0x010 preloaded with 0xDEADBEEF, RAM_LAT = 1 -> cpu_stall = 0; one cycle later cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF; vga_rvalid = 0.
2. cpu_req and vga_req held high for 20 cycles, STARVE_MAX = 4 -> grant pattern CCCCV repeating; vga_ack on cycles 4, 9, 14, 19; cpu_stall high on exactly those cycles.
3. CPU store 0x12345678 to 0x020, VGA read of 0x020 next cycle -> vga_rvalid = 1 one cycle later with vga_rdata = 0x12345678.
4. VGA read issued, reset pulsed the following cycle -> no vga_rvalid ever; starve_cnt = 0; ram_wEn = 0 during reset.
5. STARVE_MAX = 0, both masters requesting -> VGA granted every cycle, cpu_stall constantly 1. With ARB_PERF_CNT_EN, perf_cpu_stalls = 10 after 10 cycles.
